hysteresis_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator feeding the hysteresis stage of the Canny pipeline. It accepts one 8-bit non-maximum-suppressed pixel per cycle in raster order and buffers two full image rows in line buffers. For every interior pixel it presents the centre plus its eight neighbours, in the ordering the hysteresis comparator consumes, with a one-cycle enable strobe. It also flags end of frame.

---
 rtl/hysteresis_window_gen_if.sv | 32 +++
 rtl/hysteresis_window_gen.sv | 139 +++++++++++++
 tb/tb_hysteresis_window_gen.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hysteresis_window_gen_if.sv
// Pixel stream in / 3x3 neighbourhood out for the hysteresis window stage.
// master: pixel source + window sink; slave: the window generator itself.
interface hysteresis_window_gen_if;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       sof;
    logic [7:0] win0;
    logic [7:0] win1;
    logic [7:0] win2;
    logic [7:0] win3;
    logic [7:0] win4;
    logic [7:0] win5;
    logic [7:0] win6;
    logic [7:0] win7;
    logic [7:0] win8;
    logic       hysteresis_enable;
    logic       frame_done;

    modport master (
        output pixel_in, pixel_valid, sof,
        input  win0, win1, win2, win3, win4,
        input  win5, win6, win7, win8,
        input  hysteresis_enable, frame_done
    );

    modport slave (
        input  pixel_in, pixel_valid, sof,
        output win0, win1, win2, win3, win4,
        output win5, win6, win7, win8,
        output hysteresis_enable, frame_done
    );
endinterface

// File: rtl/hysteresis_window_gen.sv
// Streaming 3x3 window generator for Canny hysteresis (two line buffers).
// Ports: clk, rst (async high), bus (slave: pixels in, win0..8/strobes out).
module hysteresis_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input logic                    clk,
    input logic                    rst,
    hysteresis_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {FILL, STREAM} state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] col;
    logic [CW-1:0] col_cur;
    logic [RW-1:0] row;
    logic [RW-1:0] row_cur;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          frame_end;
    logic          emit;

    logic [7:0] lb_a [IMG_WIDTH];
    logic [7:0] lb_b [IMG_WIDTH];

    // win[row][col], row 0 = top, col 2 = newest column
    logic [2:0][2:0][7:0] win;
    logic [2:0][2:0][7:0] win_nxt;
    logic [8:0][7:0]      win_out;
    logic                 enable_q;
    logic                 done_q;

    // sof relocates the incoming pixel to (0,0) regardless of the counters
    assign accept    = bus.pixel_valid;
    assign col_cur   = bus.sof ? '0 : col;
    assign row_cur   = bus.sof ? '0 : row;
    assign col_last  = (col_cur == COL_LAST);
    assign row_last  = (row_cur == ROW_LAST);
    assign frame_end = accept && col_last && row_last;

    always_comb begin
        win_nxt = win;
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = lb_b[col_cur];
        win_nxt[1][2] = lb_a[col_cur];
        win_nxt[2][2] = bus.pixel_in;
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        if (accept) begin
            if (bus.sof) begin
                state_nxt = FILL;
            end else begin
                unique case (state)
                    FILL: begin
                        if (col_last && row_cur == RW'(1))
                            state_nxt = STREAM;
                    end
                    STREAM: begin
                        emit = (col_cur >= CW'(2));
                        if (frame_end)
                            state_nxt = FILL;
                    end
                    default: state_nxt = FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            col      <= '0;
            row      <= '0;
            win      <= '0;
            win_out  <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            enable_q <= emit;
            done_q   <= frame_end;
            if (accept) begin
                win <= win_nxt;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row_cur + RW'(1);
                end else begin
                    col <= col_cur + CW'(1);
                    row <= row_cur;
                end
            end
            // outputs only move on a real window so they hold between strobes
            if (emit) begin
                win_out[0] <= win_nxt[1][1];
                win_out[1] <= win_nxt[0][0];
                win_out[2] <= win_nxt[0][1];
                win_out[3] <= win_nxt[0][2];
                win_out[4] <= win_nxt[1][0];
                win_out[5] <= win_nxt[1][2];
                win_out[6] <= win_nxt[2][0];
                win_out[7] <= win_nxt[2][1];
                win_out[8] <= win_nxt[2][2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_b[col_cur] <= lb_a[col_cur];
            lb_a[col_cur] <= bus.pixel_in;
        end
    end

    assign bus.win0              = win_out[0];
    assign bus.win1              = win_out[1];
    assign bus.win2              = win_out[2];
    assign bus.win3              = win_out[3];
    assign bus.win4              = win_out[4];
    assign bus.win5              = win_out[5];
    assign bus.win6              = win_out[6];
    assign bus.win7              = win_out[7];
    assign bus.win8              = win_out[8];
    assign bus.hysteresis_enable = enable_q;
    assign bus.frame_done        = done_q;
endmodule

// File: tb/tb_hysteresis_window_gen.sv
// Directed bench for hysteresis_window_gen: 4x4 scenarios plus a
// random 64x64 frame checked against a neighbourhood model.
module tb_hysteresis_window_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hysteresis_window_gen_if bus4 ();
    hysteresis_window_gen_if bus64 ();

    hysteresis_window_gen #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4)
    ) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4)
    );

    hysteresis_window_gen #(
        .IMG_WIDTH (64),
        .IMG_HEIGHT(64)
    ) dut64 (
        .clk(clk),
        .rst(rst),
        .bus(bus64)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [71:0] q4 [$];
    logic [71:0] q64 [$];
    logic [71:0] exp_q [$];
    int          done4 = 0;
    int          done64 = 0;
    int          consec4 = 0;
    logic        prev_en4 = 1'b0;
    logic [7:0]  done_ctr4 = '0;
    logic        done_en4 = 1'b0;
    logic [7:0]  img64 [4096];

    function automatic logic [71:0] pack(input logic [7:0] w0,
        input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3,
        input logic [7:0] w4, input logic [7:0] w5, input logic [7:0] w6,
        input logic [7:0] w7, input logic [7:0] w8);
        return {w0, w1, w2, w3, w4, w5, w6, w7, w8};
    endfunction

    function automatic logic [7:0] p4(input int base, input int r,
        input int c);
        return 8'(base + 4 * r + c);
    endfunction

    function automatic logic [71:0] exp4(input int b, input int r,
        input int c);
        return pack(p4(b, r, c),
            p4(b, r-1, c-1), p4(b, r-1, c), p4(b, r-1, c+1),
            p4(b, r, c-1), p4(b, r, c+1),
            p4(b, r+1, c-1), p4(b, r+1, c), p4(b, r+1, c+1));
    endfunction

    function automatic logic [7:0] p64(input int r, input int c);
        return img64[r * 64 + c];
    endfunction

    function automatic logic [71:0] exp64(input int r, input int c);
        return pack(p64(r, c),
            p64(r-1, c-1), p64(r-1, c), p64(r-1, c+1),
            p64(r, c-1), p64(r, c+1),
            p64(r+1, c-1), p64(r+1, c), p64(r+1, c+1));
    endfunction

    always @(negedge clk) begin
        if (bus4.hysteresis_enable) begin
            q4.push_back(pack(bus4.win0, bus4.win1, bus4.win2,
                bus4.win3, bus4.win4, bus4.win5, bus4.win6,
                bus4.win7, bus4.win8));
            if (prev_en4)
                consec4++;
        end
        prev_en4 = bus4.hysteresis_enable;
        if (bus4.frame_done) begin
            done4++;
            done_ctr4 = bus4.win0;
            done_en4  = bus4.hysteresis_enable;
        end
        if (bus64.hysteresis_enable)
            q64.push_back(pack(bus64.win0, bus64.win1, bus64.win2,
                bus64.win3, bus64.win4, bus64.win5, bus64.win6,
                bus64.win7, bus64.win8));
        if (bus64.frame_done)
            done64++;
    end

    task automatic chk(input string tag, input logic [71:0] obs,
        input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix4(input int v, input logic s);
        bus4.pixel_in    = 8'(v);
        bus4.sof         = s;
        bus4.pixel_valid = 1'b1;
        tick();
        bus4.pixel_valid = 1'b0;
        bus4.sof         = 1'b0;
    endtask

    task automatic frame4(input int base, input int n, input bit bub);
        for (int i = 0; i < n; i++) begin
            pix4(base + i, i == 0);
            if (bub)
                tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic clear4();
        q4.delete();
        exp_q.delete();
        done4     = 0;
        consec4   = 0;
        done_ctr4 = '0;
        done_en4  = 1'b0;
    endtask

    task automatic expect4(input int base);
        exp_q.push_back(exp4(base, 1, 1));
        exp_q.push_back(exp4(base, 1, 2));
        exp_q.push_back(exp4(base, 2, 1));
        exp_q.push_back(exp4(base, 2, 2));
    endtask

    task automatic cmp_q4(input string tag);
        chk({tag, "_count"}, 72'(q4.size()), 72'(exp_q.size()));
        for (int i = 0; i < q4.size() && i < exp_q.size(); i++)
            chk({tag, "_win"}, q4[i], exp_q[i]);
    endtask

    initial begin
        bus4.pixel_in     = '0;
        bus4.pixel_valid  = 1'b0;
        bus4.sof          = 1'b0;
        bus64.pixel_in    = '0;
        bus64.pixel_valid = 1'b0;
        bus64.sof         = 1'b0;
        idle(2);

        chk("rst_win", pack(bus4.win0, bus4.win1, bus4.win2, bus4.win3,
            bus4.win4, bus4.win5, bus4.win6, bus4.win7, bus4.win8), '0);
        chk("rst_en", 72'(bus4.hysteresis_enable), 72'(0));
        chk("rst_done", 72'(bus4.frame_done), 72'(0));
        chk("rst_win64", pack(bus64.win0, bus64.win1, bus64.win2,
            bus64.win3, bus64.win4, bus64.win5, bus64.win6, bus64.win7,
            bus64.win8), '0);
        rst = 1'b0;
        idle(2);

        // basic frame with cycle-accurate strobe checks
        clear4();
        for (int i = 0; i < 16; i++) begin
            bus4.pixel_in    = 8'(i);
            bus4.sof         = (i == 0);
            bus4.pixel_valid = 1'b1;
            tick();
            if (i == 9)
                chk("basic_en_at9", 72'(bus4.hysteresis_enable), 72'(0));
            if (i == 10) begin
                chk("basic_en_at10", 72'(bus4.hysteresis_enable), 72'(1));
                chk("basic_first", pack(bus4.win0, bus4.win1, bus4.win2,
                    bus4.win3, bus4.win4, bus4.win5, bus4.win6, bus4.win7,
                    bus4.win8), pack(8'd5, 8'd0, 8'd1, 8'd2, 8'd4, 8'd6,
                    8'd8, 8'd9, 8'd10));
            end
            if (i == 12)
                chk("basic_en_at12", 72'(bus4.hysteresis_enable), 72'(0));
            if (i == 14)
                chk("basic_done_at14", 72'(bus4.frame_done), 72'(0));
            if (i == 15)
                chk("basic_done_at15", 72'(bus4.frame_done), 72'(1));
        end
        bus4.pixel_valid = 1'b0;
        bus4.sof         = 1'b0;
        tick();
        chk("basic_en_off", 72'(bus4.hysteresis_enable), 72'(0));
        chk("basic_hold", 72'(bus4.win0), 72'(10));
        idle(3);
        expect4(0);
        cmp_q4("basic");
        chk("basic_done_n", 72'(done4), 72'(1));
        chk("basic_done_ctr", 72'(done_ctr4), 72'(10));
        chk("basic_done_en", 72'(done_en4), 72'(1));

        // bubbles every other cycle
        clear4();
        frame4(0, 16, 1'b1);
        idle(3);
        expect4(0);
        cmp_q4("bubble");
        chk("bubble_consec", 72'(consec4), 72'(0));
        chk("bubble_done_n", 72'(done4), 72'(1));

        // two frames back to back
        clear4();
        frame4(0, 16, 1'b0);
        frame4(100, 16, 1'b0);
        idle(3);
        expect4(0);
        expect4(100);
        cmp_q4("b2b");
        chk("b2b_done_n", 72'(done4), 72'(2));
        chk("b2b_done_ctr", 72'(done_ctr4), 72'(110));

        // abort after nine pixels, restart with a full frame
        clear4();
        frame4(0, 9, 1'b0);
        frame4(50, 16, 1'b0);
        idle(3);
        expect4(50);
        cmp_q4("midsof");
        chk("midsof_done_n", 72'(done4), 72'(1));
        chk("midsof_done_ctr", 72'(done_ctr4), 72'(60));

        // asynchronous reset in row 2 just after the first window
        clear4();
        frame4(0, 11, 1'b0);
        chk("rst2_pre_en", 72'(bus4.hysteresis_enable), 72'(1));
        rst = 1'b1;
        #1;
        chk("rst2_win", pack(bus4.win0, bus4.win1, bus4.win2, bus4.win3,
            bus4.win4, bus4.win5, bus4.win6, bus4.win7, bus4.win8), '0);
        chk("rst2_en", 72'(bus4.hysteresis_enable), 72'(0));
        chk("rst2_done", 72'(bus4.frame_done), 72'(0));
        idle(2);
        rst = 1'b0;
        idle(1);
        clear4();
        frame4(30, 16, 1'b0);
        idle(3);
        expect4(30);
        cmp_q4("rst2");
        chk("rst2_done_n", 72'(done4), 72'(1));

        // random 64x64 frame
        for (int i = 0; i < 4096; i++)
            img64[i] = 8'($urandom_range(0, 255));
        q64.delete();
        done64 = 0;
        for (int i = 0; i < 4096; i++) begin
            bus64.pixel_in    = img64[i];
            bus64.sof         = (i == 0);
            bus64.pixel_valid = 1'b1;
            tick();
        end
        bus64.pixel_valid = 1'b0;
        bus64.sof         = 1'b0;
        idle(4);
        chk("rand_count", 72'(q64.size()), 72'(3844));
        for (int r = 1; r < 63; r++)
            for (int c = 1; c < 63; c++) begin
                int k;
                k = (r - 1) * 62 + (c - 1);
                if (k < q64.size())
                    chk("rand_win", q64[k], exp64(r, c));
            end
        chk("rand_done_n", 72'(done64), 72'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end
endmodule
